lorenz_view_controller: RTL and testbench



---
 rtl/lorenz_ui_pkg.sv | 59 +++++
 rtl/lorenz_view_controller_if.sv | 27 ++
 rtl/button_debounce.sv | 58 +++++
 rtl/lorenz_view_controller.sv | 167 ++++++++++++++++
 tb/tb_lorenz_view_controller.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lorenz_ui_pkg.sv
// Shared types and constants for the Lorenz view controller: edit modes,
// reset values, index ranges and the led/rgb status encodings.
package lorenz_ui_pkg;

  // Edit modes, kept as plain constants so older code can compare against them.
  typedef logic [2:0] modeT;
  localparam modeT modeRun  = 3'd0;
  localparam modeT modeDt   = 3'd1;
  localparam modeT modeSkip = 3'd2;
  localparam modeT modeXy   = 3'd3;
  localparam modeT modeYz   = 3'd4;

  // Index ranges; widths of the index registers follow from them.
  localparam int unsigned dtIdxRange   = 4;
  localparam int unsigned skipIdxRange = 8;
  localparam int unsigned rateRange    = 16;

  typedef logic [$clog2(dtIdxRange)-1:0]   dtIdxT;
  typedef logic [$clog2(skipIdxRange)-1:0] skipIdxT;
  typedef logic [$clog2(rateRange)-1:0]    rateT;

  localparam dtIdxT   dtIdxReset   = 2'd2;
  localparam skipIdxT skipIdxReset = 3'd3;
  localparam rateT    xyRateReset  = 4'd3;
  localparam rateT    yzRateReset  = 4'd4;

  localparam logic [3:0] ledRun  = 4'b0000;
  localparam logic [3:0] ledDt   = 4'b0001;
  localparam logic [3:0] ledSkip = 4'b0010;
  localparam logic [3:0] ledXy   = 4'b0100;
  localparam logic [3:0] ledYz   = 4'b1000;

  // Active-low colour: {r, g, b}.
  localparam logic [2:0] rgbRunning = 3'b101;
  localparam logic [2:0] rgbPaused  = 3'b110;
  localparam logic [2:0] rgbEdit    = 3'b011;

  function automatic logic [3:0] ledFor(modeT m);
    case (m)
      modeDt:   ledFor = ledDt;
      modeSkip: ledFor = ledSkip;
      modeXy:   ledFor = ledXy;
      modeYz:   ledFor = ledYz;
      default:  ledFor = ledRun;
    endcase
  endfunction

  function automatic logic [2:0] rgbFor(modeT m, logic paused);
    if (m != modeRun) rgbFor = rgbEdit;
    else if (paused)  rgbFor = rgbPaused;
    else              rgbFor = rgbRunning;
  endfunction

  // The top step is the rounded 0.0001*2^32, one LSB above the plain shift.
  function automatic logic [31:0] dtValue(logic [31:0] base, dtIdxT idx);
    dtValue = (base << idx) + ((idx == 2'd3) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/lorenz_view_controller_if.sv
// Button inputs and display-chain outputs of the view controller.
interface lorenz_view_controller_if #(
  parameter int unsigned phaseBits    = 30,
  parameter int unsigned dtBits       = 20,
  parameter int unsigned iteratorBits = 18
);
  logic [1:0]                btn;
  logic signed [dtBits-1:0]  dt;
  logic [iteratorBits-1:0]   skip;
  logic [phaseBits-1:0]      xyPhase;
  logic [phaseBits-1:0]      yzPhase;
  logic                      restart;
  logic [3:0]                led;
  logic [2:0]                rgb;

  // Controller side.
  modport master (
    input  btn,
    output dt, skip, xyPhase, yzPhase, restart, led, rgb
  );

  // Button/display side.
  modport slave (
    output btn,
    input  dt, skip, xyPhase, yzPhase, restart, led, rgb
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stable-time debounce and registered press pulse
// for one raw button.
module button_debounce #(
  parameter int unsigned debounceCycles = 65536
) (
  input  logic clk,
  input  logic resetN,
  input  logic btnRaw,
  output logic level,
  output logic press
);

  localparam int unsigned cntBits = (debounceCycles > 1) ? $clog2(debounceCycles) : 1;
  localparam logic [cntBits-1:0] cntLast = cntBits'(debounceCycles - 1);

  logic               sync0;
  logic               sync1;
  logic               levelDly;
  logic [cntBits-1:0] stableCnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btnRaw;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after it has differed for debounceCycles cycles in a row.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      stableCnt <= '0;
      level     <= 1'b0;
    end else if (sync1 == level) begin
      stableCnt <= '0;
    end else if (stableCnt == cntLast) begin
      stableCnt <= '0;
      level     <= sync1;
    end else begin
      stableCnt <= stableCnt + 1'b1;
    end
  end

  // Press pulse one cycle after the debounced rising edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      levelDly <= 1'b0;
      press    <= 1'b0;
    end else begin
      levelDly <= level;
      press    <= level & ~levelDly;
    end
  end

endmodule

// File: rtl/lorenz_view_controller.sv
// Button-driven edit FSM for dt/skip/rotation rates, step auto-repeat and the
// free-running rotation phase accumulators of the Lorenz display chain.
module lorenz_view_controller
  import lorenz_ui_pkg::*;
#(
  parameter int unsigned phaseBits      = 30,
  parameter int unsigned dtBits         = 20,
  parameter int unsigned iteratorBits   = 18,
  parameter int unsigned dtBase         = 53687,
  parameter int unsigned skipBase       = 128,
  parameter int unsigned debounceCycles = 65536,
  parameter int unsigned holdCycles     = 4194304,
  parameter int unsigned repeatCycles   = 1048576
) (
  input logic                     clk,
  input logic                     resetN,
  lorenz_view_controller_if.master bus
);

  localparam int unsigned maxHold  = (holdCycles > repeatCycles) ? holdCycles : repeatCycles;
  localparam int unsigned holdBits = (maxHold > 1) ? $clog2(maxHold) : 1;
  localparam logic [holdBits-1:0] holdLast   = holdBits'(holdCycles - 1);
  localparam logic [holdBits-1:0] repeatLast = holdBits'(repeatCycles - 1);

  logic modeLevel, modePress, stepLevel, stepPress;

  button_debounce #(.debounceCycles(debounceCycles)) uModeDebounce (
    .clk    (clk),
    .resetN (resetN),
    .btnRaw (bus.btn[0]),
    .level  (modeLevel),
    .press  (modePress)
  );

  button_debounce #(.debounceCycles(debounceCycles)) uStepDebounce (
    .clk    (clk),
    .resetN (resetN),
    .btnRaw (bus.btn[1]),
    .level  (stepLevel),
    .press  (stepPress)
  );

  // A press can only follow a cycle in which the debounced level was high.
  modePressFollowsLevel: assert property (@(posedge clk) disable iff (!resetN)
    modePress |-> $past(modeLevel));
  stepPressFollowsLevel: assert property (@(posedge clk) disable iff (!resetN)
    stepPress |-> $past(stepLevel));

  logic [holdBits-1:0] holdCnt;
  logic                repeating;
  logic                repeatFire;
  logic                stepEvt;
  logic                modeEvt;

  assign repeatFire = stepLevel && (repeating ? (holdCnt == repeatLast) : (holdCnt == holdLast));
  assign stepEvt    = stepPress | repeatFire;
  assign modeEvt    = modePress;

  // Auto-repeat timer: holdCycles to the first repeat, repeatCycles thereafter.
  always_ff @(posedge clk) begin
    if (!resetN || !stepLevel) begin
      holdCnt   <= '0;
      repeating <= 1'b0;
    end else if (stepPress || (stepEvt && modeEvt)) begin
      holdCnt   <= '0;
      repeating <= 1'b0;
    end else if (repeatFire) begin
      holdCnt   <= '0;
      repeating <= 1'b1;
    end else begin
      holdCnt <= holdCnt + 1'b1;
    end
  end

  modeT    modeQ, modeD;
  dtIdxT   dtIdxQ, dtIdxD;
  skipIdxT skipIdxQ, skipIdxD;
  rateT    xyRateQ, xyRateD, yzRateQ, yzRateD;
  logic    pausedQ, pausedD;
  logic    restartD;

  // Next edit state: a mode event beats a step event in the same cycle.
  always_comb begin
    modeD    = modeQ;
    dtIdxD   = dtIdxQ;
    skipIdxD = skipIdxQ;
    xyRateD  = xyRateQ;
    yzRateD  = yzRateQ;
    pausedD  = pausedQ;
    restartD = 1'b0;
    if (modeEvt) begin
      modeD = (modeQ == modeYz) ? modeRun : modeQ + 3'd1;
    end else if (stepEvt) begin
      case (modeQ)
        modeRun:  pausedD = ~pausedQ;
        modeDt: begin
          dtIdxD   = dtIdxQ + 1'b1;
          restartD = 1'b1;
        end
        modeSkip: begin
          skipIdxD = skipIdxQ + 1'b1;
          restartD = 1'b1;
        end
        modeXy:   xyRateD = xyRateQ + 1'b1;
        modeYz:   yzRateD = yzRateQ + 1'b1;
        default:  ;
      endcase
    end
  end

  logic signed [dtBits-1:0] dtQ;
  logic [iteratorBits-1:0]  skipQ;
  logic                     restartQ;
  logic [3:0]               ledQ;
  logic [2:0]               rgbQ;

  // Edit state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      modeQ    <= modeRun;
      dtIdxQ   <= dtIdxReset;
      skipIdxQ <= skipIdxReset;
      xyRateQ  <= xyRateReset;
      yzRateQ  <= yzRateReset;
      pausedQ  <= 1'b0;
      restartQ <= 1'b0;
      dtQ      <= dtBits'(dtValue(32'(dtBase), dtIdxReset));
      skipQ    <= iteratorBits'(32'(skipBase) << skipIdxReset);
      ledQ     <= ledRun;
      rgbQ     <= rgbRunning;
    end else begin
      modeQ    <= modeD;
      dtIdxQ   <= dtIdxD;
      skipIdxQ <= skipIdxD;
      xyRateQ  <= xyRateD;
      yzRateQ  <= yzRateD;
      pausedQ  <= pausedD;
      restartQ <= restartD;
      dtQ      <= dtBits'(dtValue(32'(dtBase), dtIdxD));
      skipQ    <= iteratorBits'(32'(skipBase) << skipIdxD);
      ledQ     <= ledFor(modeD);
      rgbQ     <= rgbFor(modeD, pausedD);
    end
  end

  logic [phaseBits-1:0] xyPhaseQ, yzPhaseQ;

  // Rotation phases advance by the current rates unless paused; wrap silently.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      xyPhaseQ <= '0;
      yzPhaseQ <= '0;
    end else if (!pausedQ) begin
      xyPhaseQ <= xyPhaseQ + phaseBits'(xyRateQ);
      yzPhaseQ <= yzPhaseQ + phaseBits'(yzRateQ);
    end
  end

  assign bus.dt      = dtQ;
  assign bus.skip    = skipQ;
  assign bus.xyPhase = xyPhaseQ;
  assign bus.yzPhase = yzPhaseQ;
  assign bus.restart = restartQ;
  assign bus.led     = ledQ;
  assign bus.rgb     = rgbQ;

endmodule

// File: tb/tb_lorenz_view_controller.sv
// Self-checking bench: directed walk through the edit modes plus random button
// activity, compared every cycle against a behavioural model of the controller.
module tb_lorenz_view_controller;

  localparam int dbCyc   = 4;
  localparam int holdCyc = 16;
  localparam int repCyc  = 8;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  lorenz_view_controller_if #(.phaseBits(30), .dtBits(20), .iteratorBits(18)) bus ();

  lorenz_view_controller #(
    .debounceCycles (dbCyc),
    .holdCycles     (holdCyc),
    .repeatCycles   (repCyc)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int vecCount    = 0;
  int missCount   = 0;
  int restartSeen = 0;

  int dtTable[4]  = '{53687, 107374, 214748, 429497};
  int ledTable[5] = '{0, 1, 2, 4, 8};

  // Reference model state.
  int          mMode, mDtIdx, mSkipIdx, mXyRate, mYzRate, mSince;
  bit          mPaused, mRestart;
  logic [29:0] mXy, mYz;
  logic [1:0]  mH1, mH2, mLvl, mLvlPrev, mPress;
  int          mRun[2];

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge with the inputs seen at that edge.
  task automatic modelStep(input logic [1:0] b, input logic r);
    bit modeEv, stepEv, rep;
    logic [1:0] newLvl;
    if (!r) begin
      mMode = 0; mDtIdx = 2; mSkipIdx = 3; mXyRate = 3; mYzRate = 4;
      mPaused = 0; mRestart = 0; mXy = '0; mYz = '0;
      mH1 = '0; mH2 = '0; mLvl = '0; mLvlPrev = '0; mPress = '0;
      mRun[0] = 0; mRun[1] = 0; mSince = -1;
    end else begin
      modeEv = mPress[0];
      rep    = mLvl[1] && (mSince >= holdCyc) && (((mSince - holdCyc) % repCyc) == 0);
      stepEv = mPress[1] || rep;
      if (!mPaused) begin
        mXy = mXy + 30'(mXyRate);
        mYz = mYz + 30'(mYzRate);
      end
      if (!mLvl[1]) mSince = -1;
      else if (mPress[1] || (stepEv && modeEv)) mSince = 1;
      else if (mSince >= 0) mSince++;
      mRestart = 0;
      if (modeEv) mMode = (mMode + 1) % 5;
      else if (stepEv) begin
        case (mMode)
          0: mPaused = !mPaused;
          1: begin mDtIdx = (mDtIdx + 1) % 4; mRestart = 1; end
          2: begin mSkipIdx = (mSkipIdx + 1) % 8; mRestart = 1; end
          3: mXyRate = (mXyRate + 1) % 16;
          default: mYzRate = (mYzRate + 1) % 16;
        endcase
      end
      newLvl = mLvl;
      for (int i = 0; i < 2; i++) begin
        if (mH2[i] != mLvl[i]) begin
          mRun[i]++;
          if (mRun[i] == dbCyc) begin
            newLvl[i] = mH2[i];
            mRun[i]   = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      mPress   = mLvl & ~mLvlPrev;
      mLvlPrev = mLvl;
      mLvl     = newLvl;
      mH2      = mH1;
      mH1      = b;
    end
  endtask

  task automatic compareAll();
    checkValue("dt", 64'(bus.dt), 64'(dtTable[mDtIdx]));
    checkValue("skip", 64'(bus.skip), 64'(128 << mSkipIdx));
    checkValue("xyPhase", 64'(bus.xyPhase), 64'(mXy));
    checkValue("yzPhase", 64'(bus.yzPhase), 64'(mYz));
    checkValue("restart", 64'(bus.restart), 64'(mRestart));
    checkValue("led", 64'(bus.led), 64'(ledTable[mMode]));
    checkValue("rgb", 64'(bus.rgb), (mMode != 0) ? 64'd3 : (mPaused ? 64'd6 : 64'd5));
  endtask

  // One or more clock cycles: model at the edge, DUT compared on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep(bus.btn, resetN);
      @(negedge clk);
      compareAll();
      if (bus.restart === 1'b1) restartSeen++;
    end
  endtask

  task automatic pulse(input int bitIdx, input int high, input int low);
    bus.btn[bitIdx] = 1'b1;
    tick(high);
    bus.btn[bitIdx] = 1'b0;
    tick(low);
  endtask

  logic [29:0] frozenXy;
  int          dur;

  initial begin
    resetN  = 1'b0;
    bus.btn = 2'b00;
    tick(3);
    resetN = 1'b1;

    // Idle after reset.
    tick(100);
    checkValue("t1_dt", 64'(bus.dt), 64'd214748);
    checkValue("t1_skip", 64'(bus.skip), 64'd1024);
    checkValue("t1_led", 64'(bus.led), 64'd0);
    checkValue("t1_rgb", 64'(bus.rgb), 64'd5);
    checkValue("t1_xyPhase", 64'(bus.xyPhase), 64'd300);
    checkValue("t1_yzPhase", 64'(bus.yzPhase), 64'd400);

    // One mode press, then a bounce that must be ignored.
    pulse(0, 10, 12);
    checkValue("t2_led", 64'(bus.led), 64'd1);
    checkValue("t2_rgb", 64'(bus.rgb), 64'd3);
    pulse(0, 2, 2);
    pulse(0, 2, 20);
    checkValue("t2_bounceLed", 64'(bus.led), 64'd1);

    // Three dt steps, wrapping at index 3.
    restartSeen = 0;
    pulse(1, 8, 12);
    checkValue("t3_dt0", 64'(bus.dt), 64'd429497);
    pulse(1, 8, 12);
    checkValue("t3_dt1", 64'(bus.dt), 64'd53687);
    pulse(1, 8, 12);
    checkValue("t3_dt2", 64'(bus.dt), 64'd107374);
    checkValue("t3_restarts", 64'(restartSeen), 64'd3);

    // Held step in SKIP: press plus five auto-repeats.
    pulse(0, 10, 12);
    checkValue("t4_led", 64'(bus.led), 64'd2);
    restartSeen = 0;
    pulse(1, 50, 20);
    checkValue("t4_restarts", 64'(restartSeen), 64'd6);
    checkValue("t4_skip", 64'(bus.skip), 64'd256);

    // xyRate 3 -> 15 -> 0, then back to RUN.
    pulse(0, 10, 12);
    checkValue("t5_ledXy", 64'(bus.led), 64'd4);
    for (int i = 0; i < 13; i++) pulse(1, 8, 12);
    pulse(0, 10, 12);
    pulse(0, 10, 12);
    checkValue("t5_ledRun", 64'(bus.led), 64'd0);
    frozenXy = mXy;
    tick(20);
    checkValue("t5_xyFrozen", 64'(bus.xyPhase), 64'(frozenXy));

    // Pause in RUN, then reset in the middle of the hold.
    bus.btn[1] = 1'b1;
    tick(12);
    checkValue("t6_rgbPaused", 64'(bus.rgb), 64'd6);
    tick(8);
    resetN  = 1'b0;
    bus.btn = 2'b00;
    tick(1);
    checkValue("t6_rstDt", 64'(bus.dt), 64'd214748);
    checkValue("t6_rstRgb", 64'(bus.rgb), 64'd5);
    checkValue("t6_rstXy", 64'(bus.xyPhase), 64'd0);
    resetN = 1'b1;
    tick(40);
    checkValue("t6_noEventRgb", 64'(bus.rgb), 64'd5);
    checkValue("t6_xyPhase", 64'(bus.xyPhase), 64'd120);

    // Random button activity with occasional resets.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        resetN = 1'b0;
        tick($urandom_range(1, 2));
        resetN = 1'b1;
      end
      bus.btn = 2'($urandom_range(0, 3));
      dur = $urandom_range(1, 40);
      tick(dur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
